// File: rtl/pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// pll_lock_sequencer
//
// Supervises the clock-generation PLL. The block runs on the free-running PLL
// reference clock and resets the PLL. It synchronises the asynchronous LOCKED
// flag and checks that it stays high. The downstream system reset is released
// only after lock has held continuously for LOCK_STABLE cycles. If lock is not
// acquired within LOCK_TIMEOUT cycles, the block retries the PLL reset and
// counts the timeout. A loss of lock while running is reported with a
// one-cycle pulse.
//
// Ports
//   CLK_IN1      in   free-running reference clock (also feeds the PLL)
//   RESET_N      in   synchronous active-low reset
//   LOCKED       in   PLL lock flag, asynchronous to CLK_IN1
//   FORCE_RELOCK in   level request to re-run the PLL reset sequence
//   PLL_RESET    out  active-high reset to the PLL
//   SYS_RESET_N  out  active-low reset for logic clocked by the PLL outputs
//   READY        out  high while the system is running
//   LOCK_LOST    out  one-cycle pulse when lock drops while running
//   RETRY_CNT    out  number of lock timeouts, saturating at 255
// -----------------------------------------------------------------------------
module pll_lock_sequencer #(
  parameter int RST_PULSE    = 8,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int CNT_W        = 17
) (
  input  logic       CLK_IN1,
  input  logic       RESET_N,
  input  logic       LOCKED,
  input  logic       FORCE_RELOCK,
  output logic       PLL_RESET,
  output logic       SYS_RESET_N,
  output logic       READY,
  output logic       LOCK_LOST,
  output logic [7:0] RETRY_CNT
);

  typedef enum logic [1:0] {
    ST_RST       = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_e;

  // Terminal counts. The counter starts at 0 on entry to a state, so the
  // state exits after exactly N cycles.
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync_meta_q, sync_meta_d;
  logic             locked_s_q, locked_s_d;
  logic             pll_reset_q, pll_reset_d;
  logic             sys_reset_n_q, sys_reset_n_d;
  logic             ready_q, ready_d;
  logic             lock_lost_q, lock_lost_d;
  logic [7:0]       retry_cnt_q, retry_cnt_d;
  logic             timeout_hit;

  // ---------------------------------------------------------------------------
  // State register: holds the FSM, the counter, the synchroniser and the
  // registered outputs.
  // ---------------------------------------------------------------------------
  // NOTE: the synchroniser flops also clear on reset. A stale lock flag must
  // not carry over into the restarted sequence.
  always_ff @(posedge CLK_IN1) begin
    if (!RESET_N) begin
      // NOTE: non-blocking assignments keep every flop sampling the pre-edge
      // values of the others, regardless of statement order.
      state_q       <= ST_RST;
      cnt_q         <= '0;
      sync_meta_q   <= 1'b0;
      locked_s_q    <= 1'b0;
      pll_reset_q   <= 1'b1;
      sys_reset_n_q <= 1'b0;
      ready_q       <= 1'b0;
      lock_lost_q   <= 1'b0;
      retry_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sync_meta_q   <= sync_meta_d;
      locked_s_q    <= locked_s_d;
      pll_reset_q   <= pll_reset_d;
      sys_reset_n_q <= sys_reset_n_d;
      ready_q       <= ready_d;
      lock_lost_q   <= lock_lost_d;
      retry_cnt_q   <= retry_cnt_d;
    end
  end

  // Two-flop synchroniser. Only locked_s_q is used downstream.
  always_comb begin
    sync_meta_d = LOCKED;
    locked_s_d  = sync_meta_q;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default every always_comb output first. Otherwise a branch that
    // skips an assignment infers a latch.
    state_d     = state_q;
    timeout_hit = 1'b0;

    unique case (state_q)
      ST_RST: begin
        // FORCE_RELOCK is deliberately ignored while the PLL is held in reset.
        if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (FORCE_RELOCK) begin
          state_d = ST_RST;
        end else if (locked_s_q) begin
          // Lock wins over a timeout that expires in the same cycle.
          state_d = ST_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d     = ST_RST;
          timeout_hit = 1'b1;
        end
      end
      ST_STABLE: begin
        if (FORCE_RELOCK)              state_d = ST_RST;
        else if (!locked_s_q)          state_d = ST_WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!locked_s_q || FORCE_RELOCK) state_d = ST_RST;
      end
      default: state_d = ST_RST;
    endcase

    // A single counter is shared by all states and restarts on every state
    // change. In RUN it simply wraps, because no decision depends on it there.
    if (state_d != state_q) cnt_d = '0;
    else                    cnt_d = cnt_q + CNT_W'(1);
  end

  // ---------------------------------------------------------------------------
  // Output logic. The outputs are decoded from the next state so that the
  // registered outputs change on the same edge as the state.
  // ---------------------------------------------------------------------------
  always_comb begin
    pll_reset_d   = (state_d == ST_RST);
    sys_reset_n_d = (state_d == ST_RUN);
    ready_d       = (state_d == ST_RUN);
    // A lock drop in RUN always reports. A simultaneous FORCE_RELOCK does
    // not suppress the report.
    lock_lost_d   = (state_q == ST_RUN) && !locked_s_q;
    retry_cnt_d   = retry_cnt_q;
    if (timeout_hit && (retry_cnt_q != 8'hFF)) retry_cnt_d = retry_cnt_q + 8'd1;
  end

  assign PLL_RESET   = pll_reset_q;
  assign SYS_RESET_N = sys_reset_n_q;
  assign READY       = ready_q;
  assign LOCK_LOST   = lock_lost_q;
  assign RETRY_CNT   = retry_cnt_q;

endmodule
